// File: rtl/hdmi_audio_pacer.sv
// hdmi_audio_pacer: fractional-rate audio sample scheduler with a prefill FIFO; optional mute input under HDMI_AUDIO_PACER_MUTE_EN
module hdmi_audio_pacer #(
    parameter int CLK_HZ     = 25200000,
    parameter int SAMPLE_HZ  = 48000,
    parameter int BIT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int PREFILL    = 4
) (
    input  logic                         clk_pixel,
    input  logic                         reset,
`ifdef HDMI_AUDIO_PACER_MUTE_EN
    input  logic                         mute,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIT_WIDTH-1:0]         in_left,
    input  logic [BIT_WIDTH-1:0]         in_right,
    output logic                         clk_audio,
    output logic [BIT_WIDTH-1:0]         audio_left,
    output logic [BIT_WIDTH-1:0]         audio_right,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [7:0]                   underrun_count,
    output logic                         playing
);
    localparam int AW = $clog2(CLK_HZ) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [AW-1:0] CLK_W     = AW'(CLK_HZ);
    localparam logic [AW-1:0] HALF_W    = AW'(CLK_HZ / 2);
    localparam logic [AW-1:0] STEP_W    = AW'(SAMPLE_HZ);
    localparam logic [LW-1:0] DEPTH_W   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PREFILL_W = LW'(PREFILL);

    typedef enum logic {PRIME, RUN} state_t;

    state_t                     state, state_n;
    logic [AW-1:0]              acc, sum;
    logic                       full_ev, mid_ev;
    logic                       push, pop, underrun, full, empty, mute_i;
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [2*BIT_WIDTH-1:0]     mem [FIFO_DEPTH];

`ifdef HDMI_AUDIO_PACER_MUTE_EN
    assign mute_i = mute;
`else
    assign mute_i = 1'b0;
`endif

    // FULL and MID are the two threshold crossings of the phase accumulator
    always_comb begin
        sum     = acc + STEP_W;
        full_ev = sum >= CLK_W;
        mid_ev  = acc < HALF_W && sum >= HALF_W && !full_ev;
        full    = fifo_level == DEPTH_W;
        empty   = fifo_level == '0;
        in_ready = !full;
        push    = in_valid && !full;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            clk_audio <= 1'b0;
        end else begin
            acc       <= full_ev ? sum - CLK_W : sum;
            clk_audio <= full_ev ? 1'b1 : (mid_ev ? 1'b0 : clk_audio);
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state   <= PRIME;
            playing <= 1'b0;
        end else begin
            state   <= state_n;
            playing <= state_n == RUN;
        end
    end

    always_comb begin
        state_n = (state == PRIME) ? ((fifo_level >= PREFILL_W) ? RUN : PRIME)
                                   : (underrun ? PRIME : RUN);
    end

    always_comb begin
        pop      = state == RUN && mid_ev && !empty;
        underrun = state == RUN && mid_ev && empty;
    end

    always_ff @(posedge clk_pixel) begin
        if (push)
            mem[wr_ptr] <= {in_left, in_right};
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            audio_left     <= '0;
            audio_right    <= '0;
            underrun_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (pop)
                {audio_left, audio_right} <= mute_i ? '0 : mem[rd_ptr];
            if (underrun && underrun_count != 8'hFF)
                underrun_count <= underrun_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_hdmi_audio_pacer.sv
// tb_hdmi_audio_pacer: directed checks on default-rate instances plus a randomized run of a fast-rate instance against a queue model
module tb_hdmi_audio_pacer;
    logic clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    int n_chk = 0;
    int n_fail = 0;

    logic        rst_d = 1'b1, valid_d = 1'b0;
    logic [15:0] l_d = '0, r_d = '0;
    logic        ready_d, ca_d, play_d;
    logic [15:0] al_d, ar_d;
    logic [3:0]  lvl_d;
    logic [7:0]  und_d;

    logic        ready_b, ca_b, play_b;
    logic [15:0] al_b, ar_b;
    logic [3:0]  lvl_b;
    logic [7:0]  und_b;

    logic        rst_f = 1'b1, valid_f = 1'b0;
    logic [15:0] l_f = '0, r_f = '0;
    logic        ready_f, ca_f, play_f;
    logic [15:0] al_f, ar_f;
    logic [3:0]  lvl_f;
    logic [7:0]  und_f;

    hdmi_audio_pacer u_def (
        .clk_pixel(clk_pixel), .reset(rst_d), .in_valid(valid_d), .in_ready(ready_d),
        .in_left(l_d), .in_right(r_d), .clk_audio(ca_d), .audio_left(al_d), .audio_right(ar_d),
        .fifo_level(lvl_d), .underrun_count(und_d), .playing(play_d)
    );

    hdmi_audio_pacer #(.PREFILL(8)) u_bp (
        .clk_pixel(clk_pixel), .reset(rst_d), .in_valid(valid_d), .in_ready(ready_b),
        .in_left(l_d), .in_right(r_d), .clk_audio(ca_b), .audio_left(al_b), .audio_right(ar_b),
        .fifo_level(lvl_b), .underrun_count(und_b), .playing(play_b)
    );

    hdmi_audio_pacer #(.CLK_HZ(1000), .SAMPLE_HZ(130)) u_fast (
        .clk_pixel(clk_pixel), .reset(rst_f), .in_valid(valid_f), .in_ready(ready_f),
        .in_left(l_f), .in_right(r_f), .clk_audio(ca_f), .audio_left(al_f), .audio_right(ar_f),
        .fifo_level(lvl_f), .underrun_count(und_f), .playing(play_f)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // posedges of clk_pixel since u_def left reset
    int cyc_def = 0;
    initial forever begin
        @(posedge clk_pixel or posedge rst_d);
        if (rst_d) cyc_def = 0;
        else cyc_def++;
    end

    // Reference model for u_fast: sample events come from closed-form crossings of n*SAMPLE_HZ
    localparam longint FC = 1000, FS = 130, FH = 500;
    localparam int FD = 8, FP = 4;
    logic [31:0] mq[$];
    longint      mn;
    bit          m_run, m_clk, chk_f = 1'b0;
    logic [15:0] m_l, m_r;
    int          m_cnt, m_und;

    task automatic model_step();
        longint p0, p1;
        bit f, md, acc_in, run0;
        int sz;
        logic [31:0] w;
        if (rst_f) begin
            mq.delete();
            mn = 0; m_run = 0; m_clk = 0; m_l = '0; m_r = '0; m_cnt = 0; m_und = 0;
        end else begin
            p0 = mn * FS;
            p1 = p0 + FS;
            f  = (p1 / FC) != (p0 / FC);
            md = ((p1 + FC - FH) / FC) != ((p0 + FC - FH) / FC) && !f;
            sz = mq.size();
            acc_in = valid_f && sz < FD;
            run0 = m_run;
            if (md && run0) begin
                if (sz > 0) begin
                    w = mq.pop_front();
                    m_l = w[31:16];
                    m_r = w[15:0];
                end else begin
                    m_und++;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            m_run = run0 ? !(md && sz == 0) : (sz >= FP);
            if (acc_in) mq.push_back({l_f, r_f});
            if (f) m_clk = 1;
            else if (md) m_clk = 0;
            mn++;
        end
    endtask

    initial forever begin
        @(posedge clk_pixel);
        model_step();
    end

    initial forever begin
        @(negedge clk_pixel);
        if (chk_f) begin
            chk("f_clk_audio", 64'(ca_f), 64'(m_clk));
            chk("f_left", 64'(al_f), 64'(m_l));
            chk("f_right", 64'(ar_f), 64'(m_r));
            chk("f_level", 64'(lvl_f), 64'(mq.size()));
            chk("f_ready", 64'(ready_f), 64'(mq.size() < FD));
            chk("f_playing", 64'(play_f), 64'(m_run));
            chk("f_underruns", 64'(und_f), 64'(m_cnt));
        end
    end

    typedef struct {
        logic       valid;
        logic [3:0] level;
        logic       ready;
        logic       play;
    } bp_vec_t;

    task automatic wait_cyc(input int target);
        while (cyc_def < target) @(negedge clk_pixel);
    endtask

    task automatic run_def();
        bp_vec_t bp_tbl[12];
        logic [15:0] pl[8], pr[8], prev;
        int nr, last_rise, h;
        bit prev_ca;
        bp_tbl = '{'{1'b1, 4'd1, 1'b1, 1'b0}, '{1'b1, 4'd2, 1'b1, 1'b0}, '{1'b1, 4'd3, 1'b1, 1'b0},
                   '{1'b1, 4'd4, 1'b1, 1'b0}, '{1'b1, 4'd5, 1'b1, 1'b0}, '{1'b1, 4'd6, 1'b1, 1'b0},
                   '{1'b1, 4'd7, 1'b1, 1'b0}, '{1'b1, 4'd8, 1'b0, 1'b0}, '{1'b1, 4'd8, 1'b0, 1'b1},
                   '{1'b1, 4'd8, 1'b0, 1'b1}, '{1'b0, 4'd8, 1'b0, 1'b1}, '{1'b0, 4'd8, 1'b0, 1'b1}};
        for (int k = 0; k < 8; k++) begin
            pl[k] = 16'h1000 + 16'(k);
            pr[k] = 16'h2000 + 16'(k);
        end
        repeat (3) @(negedge clk_pixel);
        chk("rst_clk_audio", 64'(ca_d), 0);
        chk("rst_left", 64'(al_d), 0);
        chk("rst_right", 64'(ar_d), 0);
        chk("rst_level", 64'(lvl_d), 0);
        chk("rst_underruns", 64'(und_d), 0);
        chk("rst_playing", 64'(play_d), 0);
        chk("rst_ready", 64'(ready_d), 1);
        rst_d = 1'b0;
        for (int i = 0; i < 12; i++) begin
            valid_d = bp_tbl[i].valid;
            l_d = 16'(i + 1);
            r_d = ~16'(i + 1);
            @(negedge clk_pixel);
            chk("bp_level", 64'(lvl_b), 64'(bp_tbl[i].level));
            chk("bp_ready", 64'(ready_b), 64'(bp_tbl[i].ready));
            chk("bp_playing", 64'(play_b), 64'(bp_tbl[i].play));
        end
        rst_d = 1'b1;
        repeat (2) @(negedge clk_pixel);
        rst_d = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_d = 1'b1; l_d = pl[k]; r_d = pr[k];
            @(negedge clk_pixel);
        end
        valid_d = 1'b0;
        repeat (20) @(negedge clk_pixel);
        chk("pre3_playing", 64'(play_d), 0);
        chk("pre3_left", 64'(al_d), 0);
        chk("pre3_right", 64'(ar_d), 0);
        chk("pre3_level", 64'(lvl_d), 3);
        valid_d = 1'b1; l_d = pl[3]; r_d = pr[3];
        @(negedge clk_pixel);
        valid_d = 1'b0;
        @(negedge clk_pixel);
        chk("pre4_playing", 64'(play_d), 1);
        chk("pre4_level", 64'(lvl_d), 4);
        prev = '0;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 600 && al_d === prev; t++) @(negedge clk_pixel);
            chk("mid_left", 64'(al_d), 64'(pl[k]));
            chk("mid_right", 64'(ar_d), 64'(pr[k]));
            chk("mid_cycle", 64'(cyc_def), 64'(263 + 525 * k));
            chk("mid_level", 64'(lvl_d), 64'(3 - k));
            prev = pl[k];
        end
        wait_cyc(2362);
        chk("pre_underrun_count", 64'(und_d), 0);
        chk("pre_underrun_playing", 64'(play_d), 1);
        wait_cyc(2363);
        chk("underrun_count", 64'(und_d), 1);
        chk("underrun_playing", 64'(play_d), 0);
        chk("underrun_hold", 64'(al_d), 64'(pl[3]));
        for (int k = 4; k < 8; k++) begin
            valid_d = 1'b1; l_d = pl[k]; r_d = pr[k];
            @(negedge clk_pixel);
        end
        valid_d = 1'b0;
        repeat (2) @(negedge clk_pixel);
        chk("refill_playing", 64'(play_d), 1);
        wait_cyc(2888);
        chk("refill_left", 64'(al_d), 64'(pl[4]));
        chk("refill_right", 64'(ar_d), 64'(pr[4]));
        nr = 0; last_rise = 0;
        prev_ca = ca_d;
        valid_d = 1'b1;
        for (int t = 0; t < 101 * 525 + 600 && nr < 101; t++) begin
            l_d = l_d + 16'd1;
            r_d = r_d + 16'd1;
            @(negedge clk_pixel);
            if (ca_d && !prev_ca) begin
                if (nr > 0) chk("cad_period", 64'(cyc_def - last_rise), 525);
                chk("cad_phase", 64'(cyc_def % 525), 0);
                last_rise = cyc_def;
                nr++;
            end
            if (!ca_d && prev_ca && nr > 0) begin
                h = cyc_def - last_rise;
                n_chk++;
                if (!(h == 262 || h == 263)) begin
                    n_fail++;
                    $display("FAIL cad_high: got %0d, expected 262 or 263", h);
                end
            end
            prev_ca = ca_d;
        end
        chk("cad_rises", 64'(nr), 101);
        valid_d = 1'b0;
        rst_d = 1'b1;
        repeat (2) @(negedge clk_pixel);
        rst_d = 1'b0;
        for (int k = 0; k < 6; k++) begin
            valid_d = 1'b1; l_d = 16'h3000 + 16'(k); r_d = 16'h4000 + 16'(k);
            @(negedge clk_pixel);
        end
        valid_d = 1'b0;
        wait_cyc(700);
        chk("ar_pre_clk_audio", 64'(ca_d), 1);
        chk("ar_pre_level", 64'(lvl_d), 5);
        chk("ar_pre_left", 64'(al_d), 64'(16'h3000));
        #2 rst_d = 1'b1;
        #1;
        chk("ar_clk_audio", 64'(ca_d), 0);
        chk("ar_left", 64'(al_d), 0);
        chk("ar_right", 64'(ar_d), 0);
        chk("ar_level", 64'(lvl_d), 0);
        chk("ar_playing", 64'(play_d), 0);
        chk("ar_ready", 64'(ready_d), 1);
        repeat (2) @(negedge clk_pixel);
        rst_d = 1'b0;
        for (int t = 0; t < 700 && ca_d !== 1'b1; t++) @(negedge clk_pixel);
        chk("ar_first_rise", 64'(cyc_def), 525);
    endtask

    task automatic run_fast();
        int pct[6];
        int base;
        bit timed_out;
        pct = '{10, 20, 40, 70, 95, 5};
        repeat (3) @(negedge clk_pixel);
        chk_f = 1'b1;
        rst_f = 1'b0;
        for (int b = 0; b < 6; b++) begin
            for (int t = 0; t < 500; t++) begin
                valid_f = $urandom_range(0, 99) < pct[b];
                l_f = 16'($urandom);
                r_f = 16'($urandom);
                @(negedge clk_pixel);
            end
        end
        timed_out = 1'b0;
        while (m_und < 300 && !timed_out) begin
            base = m_und;
            for (int j = 0; j < 4; j++) begin
                valid_f = 1'b1;
                l_f = 16'($urandom);
                r_f = 16'($urandom);
                @(negedge clk_pixel);
            end
            valid_f = 1'b0;
            for (int t = 0; t < 300 && m_und == base; t++) @(negedge clk_pixel);
            if (m_und == base) begin
                timed_out = 1'b1;
                n_chk++;
                n_fail++;
                $display("FAIL sat_wait: no underrun within 300 cycles, count %0d", und_f);
            end
        end
        @(negedge clk_pixel);
        chk("sat_count", 64'(und_f), 255);
        chk_f = 1'b0;
    endtask

    initial begin
        fork
            run_def();
            run_fast();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
